// File: rtl/fir_pkg.sv
// Shared constants, default-width types and the coefficient generator for the fir filter.
package fir_pkg;

  // Guard bits above the raw product width; enough headroom for up to 32 taps.
  localparam int unsigned OUT_EXTRA = 5;

  localparam int unsigned DefWidth      = 16;
  localparam int unsigned DefCoeffWidth = 16;

  typedef logic signed [DefWidth-1:0]                         sample_t;
  typedef logic signed [DefCoeffWidth-1:0]                    coeff_t;
  typedef logic signed [DefWidth+DefCoeffWidth+OUT_EXTRA-1:0] acc_t;

  // Triangular window: c[k] = min(k+1, taps-k) scaled by 2^(coeff_width-6).
  function automatic int fir_coeff(input int k, input int taps, input int coeff_width);
    int m;
    m = (k + 1 < taps - k) ? k + 1 : taps - k;
    return m <<< (coeff_width - 6);
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Combinational signed binary adder tree summing N equal-width terms.
// Inputs are padded with zeros up to the next power of two; node 0 is the root,
// node i has children 2i+1 and 2i+2, leaves occupy the last Leaves slots.
module fir_adder_tree #(
  parameter int N = 2,
  parameter int W = 37
) (
  input  logic signed [W-1:0] terms_i [N],
  output logic signed [W-1:0] sum_o
);

  localparam int Levels = (N > 1) ? $clog2(N) : 1;
  localparam int Leaves = 1 << Levels;

  logic signed [W-1:0] node [2*Leaves-1];

  for (genvar i = 0; i < Leaves; i++) begin : g_leaf
    if (i < N) begin : g_term
      assign node[Leaves-1+i] = terms_i[i];
    end else begin : g_pad
      assign node[Leaves-1+i] = '0;
    end
  end

  for (genvar i = 0; i < Leaves - 1; i++) begin : g_node
    assign node[i] = node[2*i+1] + node[2*i+2];
  end

  assign sum_o = node[0];

endmodule

// File: rtl/fir.sv
// Fully parallel direct-form FIR with a fixed symmetric triangular window.
// Optional macro FIR_PIPE_EN inserts a register stage between the multipliers
// and the adder tree, adding one cycle of latency without changing values.
module fir
  import fir_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int TAPS        = 25
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [WIDTH-1:0]                       in,
  output logic signed [WIDTH+COEFF_WIDTH+OUT_EXTRA-1:0] out
);

  localparam int AccW = WIDTH + COEFF_WIDTH + OUT_EXTRA;

  if (TAPS < 2 || TAPS > 32) begin : g_bad_taps
    $error("fir: TAPS must be in 2..32");
  end

  logic signed [WIDTH-1:0] x_q [TAPS];
  logic signed [WIDTH-1:0] x_d [TAPS];
  logic signed [AccW-1:0]  prod [TAPS];
  logic signed [AccW-1:0]  tree_in [TAPS];
  logic signed [AccW-1:0]  out_d;
  logic signed [AccW-1:0]  out_q;

  // Delay line shifts one position per clock, newest sample at x[0].
  always_comb begin
    x_d[0] = in;
    for (int k = 1; k < TAPS; k++) begin
      x_d[k] = x_q[k-1];
    end
  end

  // Delay line register; reset discards all history.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '{default: '0};
    end else begin
      x_q <= x_d;
    end
  end

  // Both operands are sign-extended to the accumulator width, so the low AccW
  // bits of the product are exact.
  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    localparam logic signed [AccW-1:0] Coeff = AccW'(fir_coeff(k, TAPS, COEFF_WIDTH));
    logic signed [AccW-1:0] x_ext;
    assign x_ext   = $signed({{(AccW-WIDTH){x_q[k][WIDTH-1]}}, x_q[k]});
    assign prod[k] = x_ext * Coeff;
  end

`ifdef FIR_PIPE_EN
  logic signed [AccW-1:0] prod_q [TAPS];

  // Product pipeline stage, cleared with the rest of the datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '{default: '0};
    end else begin
      prod_q <= prod;
    end
  end

  assign tree_in = prod_q;
`else
  assign tree_in = prod;
`endif

  fir_adder_tree #(
    .N (TAPS),
    .W (AccW)
  ) u_adder_tree (
    .terms_i (tree_in),
    .sum_o   (out_d)
  );

  // Output register holds the full-precision sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_fir.sv
// Self-checking bench for fir: fixed scenarios plus random and chirp stimulus
// compared against a convolution model built from the sample history.
module tb_fir;

  localparam int Width  = 16;
  localparam int CWidth = 16;
  localparam int Taps   = 25;
  localparam int OutW   = Width + CWidth + 5;
`ifdef FIR_PIPE_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 1;
`endif

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic signed [Width-1:0] in_s = '0;
  logic signed [OutW-1:0]  out_s;

  int     errors = 0;
  int     checks = 0;
  longint coef [Taps];
  longint hist [$];
  longint exp_m;
  longint dc_seq [64];

  fir #(
    .WIDTH       (Width),
    .COEFF_WIDTH (CWidth),
    .TAPS        (Taps)
  ) dut (
    .clk (clk),
    .rst (rst),
    .in  (in_s),
    .out (out_s)
  );

  always #5 clk = ~clk;

  // Drive one edge and update the model: out after an edge equals
  // sum_k c[k] * (sample captured Lat+k edges earlier), zero before reset release.
  task automatic step(input longint s, input bit r);
    longint acc;
    in_s = s[Width-1:0];
    rst  = r;
    @(posedge clk);
    #1;
    if (r) begin
      hist.delete();
    end else begin
      hist.push_front(s);
      if (hist.size() > Taps + 2) void'(hist.pop_back());
    end
    acc = 0;
    for (int k = 0; k < Taps; k++) begin
      if (k + Lat < hist.size()) acc += coef[k] * hist[k+Lat];
    end
    exp_m = acc;
  endtask

  task automatic test_reset();
    for (int j = 0; j < 2; j++) begin
      step(12345, 1'b1);
      checks++;
      if (longint'(out_s) !== 64'sd0) begin
        errors++;
        $display("FAIL reset_hold edge=%0d got=%0d exp=0", j, longint'(out_s));
      end
    end
    for (int j = 0; j < Taps + 3; j++) begin
      step(0, 1'b0);
      checks++;
      if (longint'(out_s) !== 64'sd0) begin
        errors++;
        $display("FAIL reset_release cyc=%0d got=%0d exp=0", j, longint'(out_s));
      end
    end
  endtask

  task automatic test_impulse();
    longint e;
    step(1, 1'b0);
    checks++;
    if (longint'(out_s) !== 64'sd0) begin
      errors++;
      $display("FAIL impulse_pre got=%0d exp=0", longint'(out_s));
    end
    for (int j = 1; j <= Taps + 3; j++) begin
      step(0, 1'b0);
      e = (j >= Lat && j - Lat < Taps) ? coef[j-Lat] : 0;
      checks++;
      if (longint'(out_s) !== e) begin
        errors++;
        $display("FAIL impulse cyc=%0d got=%0d exp=%0d", j, longint'(out_s), e);
      end
    end
  endtask

  task automatic test_dc_step();
    step(0, 1'b1);
    for (int j = 0; j < Taps + Lat + 4; j++) begin
      step(32767, 1'b0);
      dc_seq[j] = exp_m;
      checks++;
      if (longint'(out_s) !== exp_m) begin
        errors++;
        $display("FAIL dc_ramp cyc=%0d got=%0d exp=%0d", j, longint'(out_s), exp_m);
      end
    end
    checks++;
    if (longint'(out_s) !== 64'sd5670525952) begin
      errors++;
      $display("FAIL dc_settle got=%0d exp=5670525952", longint'(out_s));
    end
  endtask

  task automatic test_neg_full_scale();
    for (int j = 0; j < Taps + Lat + 4; j++) begin
      step(-32768, 1'b0);
      checks++;
      if (longint'(out_s) !== exp_m) begin
        errors++;
        $display("FAIL neg_ramp cyc=%0d got=%0d exp=%0d", j, longint'(out_s), exp_m);
      end
    end
    checks++;
    if (longint'(out_s) !== -64'sd5670699008) begin
      errors++;
      $display("FAIL neg_settle got=%0d exp=-5670699008", longint'(out_s));
    end
  endtask

  task automatic test_mid_reset();
    step(0, 1'b1);
    for (int j = 0; j < 10; j++) step(32767, 1'b0);
    step(32767, 1'b1);
    checks++;
    if (longint'(out_s) !== 64'sd0) begin
      errors++;
      $display("FAIL midreset_clear got=%0d exp=0", longint'(out_s));
    end
    for (int j = 0; j < Taps + Lat + 4; j++) begin
      step(32767, 1'b0);
      checks++;
      if (longint'(out_s) !== dc_seq[j]) begin
        errors++;
        $display("FAIL midreset_ramp cyc=%0d got=%0d exp=%0d", j, longint'(out_s), dc_seq[j]);
      end
    end
  endtask

  task automatic test_random();
    logic signed [Width-1:0] r16;
    bit                      r;
    step(0, 1'b1);
    for (int j = 0; j < 300; j++) begin
      r16 = Width'($urandom);
      r   = ($urandom_range(49) == 0);
      step(longint'(r16), r);
      checks++;
      if (longint'(out_s) !== exp_m) begin
        errors++;
        $display("FAIL random cyc=%0d rst=%0d got=%0d exp=%0d", j, r, longint'(out_s), exp_m);
      end
    end
  endtask

  task automatic test_chirp();
    real    phase;
    real    f;
    longint v;
    phase = 0.0;
    step(0, 1'b1);
    for (int n = 0; n < 800; n++) begin
      f     = 0.1 * n;
      phase = phase + 2.0 * 3.14159265358979 * f / 2000.0;
      v     = longint'($rtoi(32768.0 * $sin(phase)));
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
      step(v, 1'b0);
      checks++;
      if (longint'(out_s) !== exp_m) begin
        errors++;
        $display("FAIL chirp n=%0d got=%0d exp=%0d", n, longint'(out_s), exp_m);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < Taps; k++) begin
      coef[k] = ((k + 1 < Taps - k) ? k + 1 : Taps - k) * 1024;
    end
    exp_m = 0;
    test_reset();
    test_impulse();
    test_dc_step();
    test_neg_full_scale();
    test_mid_reset();
    test_random();
    test_chirp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
